// File: rtl/spi_sched_pkg.sv
// ============================================================================
// spi_sched_pkg : shared types and constants for the SPI configuration scheduler
// Revision      : 1.0
// ============================================================================
`default_nettype none

package spi_sched_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GAP       = 2'd2
  } state_t;

  localparam logic [1:0] OWNER_NONE  = 2'd0;
  localparam logic [1:0] OWNER_HOST  = 2'd1;
  localparam logic [1:0] OWNER_SWEEP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/spi_rr_arb2.sv
// ============================================================================
// spi_rr_arb2 : combinational two-input round-robin pick (host vs sweep)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_rr_arb2
  import spi_sched_pkg::*;
(
  input  logic       host_req_i,
  input  logic       sweep_req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = OWNER_NONE;
    if (host_req_i && sweep_req_i) begin
      // On a tie the requester that did not win last time goes first.
      grant_o = (last_grant_i == OWNER_HOST) ? OWNER_SWEEP : OWNER_HOST;
    end else if (host_req_i) begin
      grant_o = OWNER_HOST;
    end else if (sweep_req_i) begin
      grant_o = OWNER_SWEEP;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_cfg_scheduler.sv
// ============================================================================
// spi_cfg_scheduler : shares one 16-bit SPI master between host and sweep paths
// Revision          : 1.0
// ============================================================================
`default_nettype none

module spi_cfg_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              HostReq,
  input  logic [WORD_W-1:0] HostData,
  output logic              HostDone,
  input  logic              SweepReq,
  input  logic [WORD_W-1:0] SweepData,
  output logic              SweepDone,
  output logic [WORD_W-1:0] SpiSerialData,
  output logic              SpiDataoutStart,
  input  logic              SpiDataoutDone,
  output logic              Busy,
  output logic [1:0]        Grant,
  output logic              TimeoutErr,
  input  logic              ErrClear
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic              host_done_q, host_done_d;
  logic              sweep_done_q, sweep_done_d;
  logic              err_q, err_d;
  logic [1:0]        pick;

  spi_rr_arb2 u_arb (
    .host_req_i   (HostReq),
    .sweep_req_i  (SweepReq),
    .last_grant_i (last_q),
    .grant_o      (pick)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= OWNER_NONE;
      last_q       <= OWNER_SWEEP;
      data_q       <= '0;
      start_q      <= 1'b0;
      host_done_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      data_q       <= data_d;
      start_q      <= start_d;
      host_done_q  <= host_done_d;
      sweep_done_q <= sweep_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_d       = last_q;
    data_d       = data_q;
    start_d      = 1'b0;
    host_done_d  = 1'b0;
    sweep_done_d = 1'b0;
    err_d        = ErrClear ? 1'b0 : err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick != OWNER_NONE) begin
          grant_d = pick;
          last_d  = pick;
          data_d  = (pick == OWNER_HOST) ? HostData : SweepData;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (SpiDataoutDone || (cnt_q == TMO_LAST)) begin
          // A timeout sets the flag even if ErrClear is asserted this cycle.
          if (!SpiDataoutDone) begin
            err_d = 1'b1;
          end
          host_done_d  = (grant_q == OWNER_HOST);
          sweep_done_d = (grant_q == OWNER_SWEEP);
          grant_d      = OWNER_NONE;
          cnt_d        = '0;
          state_d      = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign HostDone        = host_done_q;
  assign SweepDone       = sweep_done_q;
  assign SpiSerialData   = data_q;
  assign SpiDataoutStart = start_q;
  assign Busy            = (state_q != ST_IDLE);
  assign Grant           = grant_q;
  assign TimeoutErr      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cfg_scheduler.sv
// ============================================================================
// tb_spi_cfg_scheduler : directed self-checking bench for spi_cfg_scheduler
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_spi_cfg_scheduler;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        HostReq = 1'b0, SweepReq = 1'b0, SpiDataoutDone = 1'b0, ErrClear = 1'b0;
  logic [15:0] HostData = '0, SweepData = '0;
  logic        HostDone, SweepDone, SpiDataoutStart, Busy, TimeoutErr;
  logic [15:0] SpiSerialData;
  logic [1:0]  Grant;

  // Second instance with no inter-transfer gap.
  logic        z_SweepReq = 1'b0, z_SpiDataoutDone = 1'b0;
  logic [15:0] z_SweepData = '0;
  logic        z_HostDone, z_SweepDone, z_Start, z_Busy, z_TimeoutErr;
  logic [15:0] z_SerialData;
  logic [1:0]  z_Grant;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int host_done_cnt = 0, sweep_done_cnt = 0, start_cnt = 0;

  always #5 Clk = ~Clk;

  spi_cfg_scheduler #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(255)) dut (
    .Clk(Clk), .reset_n(reset_n),
    .HostReq(HostReq), .HostData(HostData), .HostDone(HostDone),
    .SweepReq(SweepReq), .SweepData(SweepData), .SweepDone(SweepDone),
    .SpiSerialData(SpiSerialData), .SpiDataoutStart(SpiDataoutStart),
    .SpiDataoutDone(SpiDataoutDone), .Busy(Busy), .Grant(Grant),
    .TimeoutErr(TimeoutErr), .ErrClear(ErrClear)
  );

  spi_cfg_scheduler #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(40)) dut_g0 (
    .Clk(Clk), .reset_n(reset_n),
    .HostReq(1'b0), .HostData(16'h0000), .HostDone(z_HostDone),
    .SweepReq(z_SweepReq), .SweepData(z_SweepData), .SweepDone(z_SweepDone),
    .SpiSerialData(z_SerialData), .SpiDataoutStart(z_Start),
    .SpiDataoutDone(z_SpiDataoutDone), .Busy(z_Busy), .Grant(z_Grant),
    .TimeoutErr(z_TimeoutErr), .ErrClear(1'b0)
  );

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (HostDone)        host_done_cnt  <= host_done_cnt + 1;
    if (SweepDone)       sweep_done_cnt <= sweep_done_cnt + 1;
    if (SpiDataoutStart) start_cnt      <= start_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Advance until the selected instance shows a start pulse; flags a miss.
  task automatic wait_start(input bit zero_gap, input string tag);
    int n = 0;
    while (!(zero_gap ? z_Start : SpiDataoutStart) && n < 40) begin
      tick();
      n++;
    end
    check_val({tag, "_start_seen"}, 32'(zero_gap ? z_Start : SpiDataoutStart), 32'd1);
  endtask

  task automatic pulse_done();
    SpiDataoutDone = 1'b1;
    tick();
    SpiDataoutDone = 1'b0;
  endtask

  initial begin
    int t_start, t_prev, n, hd0, sd0, st0;
    logic [1:0]  exp_grant [4];
    logic [15:0] exp_data  [4];
    exp_grant = '{2'd1, 2'd2, 2'd1, 2'd2};
    exp_data  = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};

    // Reset state
    tick();
    check_val("rst_busy",  32'(Busy), 32'd0);
    check_val("rst_grant", 32'(Grant), 32'd0);
    check_val("rst_start", 32'(SpiDataoutStart), 32'd0);
    check_val("rst_data",  32'(SpiSerialData), 32'd0);
    check_val("rst_err",   32'(TimeoutErr), 32'd0);
    check_val("rst_done",  32'({HostDone, SweepDone}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single host transfer, done 36 cycles after start
    st0 = start_cnt; sd0 = sweep_done_cnt;
    HostData = 16'hA5C3; HostReq = 1'b1;
    tick();
    check_val("t1_start", 32'(SpiDataoutStart), 32'd1);
    check_val("t1_grant", 32'(Grant), 32'd1);
    check_val("t1_data",  32'(SpiSerialData), 32'hA5C3);
    check_val("t1_busy",  32'(Busy), 32'd1);
    tick();
    check_val("t1_start_1cyc", 32'(SpiDataoutStart), 32'd0);
    repeat (34) tick();
    check_val("t1_no_early_done", 32'(HostDone), 32'd0);
    pulse_done();
    check_val("t1_hostdone", 32'(HostDone), 32'd1);
    check_val("t1_grant_gap", 32'(Grant), 32'd0);
    HostReq = 1'b0;
    tick();
    check_val("t1_hostdone_1cyc", 32'(HostDone), 32'd0);
    tick(); tick();
    check_val("t1_busy_in_gap", 32'(Busy), 32'd1);
    tick();
    check_val("t1_busy_after_gap", 32'(Busy), 32'd0);
    check_val("t1_one_start", 32'(start_cnt - st0), 32'd1);
    check_val("t1_no_sweepdone", 32'(sweep_done_cnt - sd0), 32'd0);
    check_val("t1_data_hold", 32'(SpiSerialData), 32'hA5C3);

    // Both requesters held from reset: host, sweep, host, sweep
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    HostData = 16'h1111; SweepData = 16'h2222;
    HostReq = 1'b1; SweepReq = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_start(1'b0, "rr");
      t_start = cyc;
      check_val($sformatf("rr%0d_grant", i), 32'(Grant), 32'(exp_grant[i]));
      check_val($sformatf("rr%0d_data", i), 32'(SpiSerialData), 32'(exp_data[i]));
      // Done sampled 6 edges after start, then 4 gap cycles: next start 11 edges later.
      if (i > 0) check_val($sformatf("rr%0d_spacing", i), 32'(t_start - t_prev), 32'd11);
      t_prev = t_start;
      repeat (5) tick();
      pulse_done();
      if (i == 3) begin
        HostReq = 1'b0; SweepReq = 1'b0;
      end
    end
    repeat (5) tick();
    check_val("rr_idle", 32'(Busy), 32'd0);

    // Timeout, then clear
    HostData = 16'h0F0F; HostReq = 1'b1;
    wait_start(1'b0, "to1");
    n = 0;
    while (!HostDone && n < 300) begin
      tick();
      n++;
    end
    check_val("to1_latency", 32'(n), 32'd256);
    check_val("to1_err", 32'(TimeoutErr), 32'd1);
    HostReq = 1'b0;
    repeat (5) tick();
    ErrClear = 1'b1; tick(); ErrClear = 1'b0;
    check_val("to1_cleared", 32'(TimeoutErr), 32'd0);

    // Timeout coincident with ErrClear: set wins
    HostReq = 1'b1;
    wait_start(1'b0, "to2");
    repeat (255) tick();
    check_val("to2_no_early_done", 32'(HostDone), 32'd0);
    ErrClear = 1'b1; tick(); ErrClear = 1'b0;
    check_val("to2_done", 32'(HostDone), 32'd1);
    check_val("to2_set_wins", 32'(TimeoutErr), 32'd1);
    HostReq = 1'b0;
    repeat (5) tick();
    ErrClear = 1'b1; tick(); ErrClear = 1'b0;

    // Request dropped mid-transfer; spurious done in GAP and IDLE
    HostData = 16'h5A5A; HostReq = 1'b1;
    wait_start(1'b0, "drop");
    tick(); tick();
    HostReq = 1'b0;
    repeat (3) tick();
    pulse_done();
    check_val("drop_hostdone", 32'(HostDone), 32'd1);
    tick();
    hd0 = host_done_cnt; sd0 = sweep_done_cnt;
    pulse_done();
    check_val("spur_gap_nodone", 32'({HostDone, SweepDone}), 32'd0);
    repeat (4) tick();
    check_val("spur_idle_state", 32'(Busy), 32'd0);
    pulse_done();
    tick();
    check_val("spur_idle_nodone", 32'({HostDone, SweepDone}), 32'd0);
    check_val("spur_cnt", 32'((host_done_cnt - hd0) + (sweep_done_cnt - sd0)), 32'd0);
    check_val("spur_still_idle", 32'(Busy), 32'd0);

    // Reset during WAIT_DONE
    SweepData = 16'hC0DE; SweepReq = 1'b1;
    wait_start(1'b0, "rst_mid");
    repeat (3) tick();
    sd0 = sweep_done_cnt;
    reset_n = 1'b0; SweepReq = 1'b0;
    #1;
    check_val("rstmid_busy",  32'(Busy), 32'd0);
    check_val("rstmid_grant", 32'(Grant), 32'd0);
    check_val("rstmid_data",  32'(SpiSerialData), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check_val("rstmid_nodone", 32'(sweep_done_cnt - sd0), 32'd0);
    SweepData = 16'h3C3C; SweepReq = 1'b1;
    tick();
    check_val("rstmid_regrant_start", 32'(SpiDataoutStart), 32'd1);
    check_val("rstmid_regrant_grant", 32'(Grant), 32'd2);
    check_val("rstmid_regrant_data",  32'(SpiSerialData), 32'h3C3C);
    tick();
    pulse_done();
    check_val("rstmid_sweepdone", 32'(SweepDone), 32'd1);
    SweepReq = 1'b0;

    // GAP_CYCLES=0: back-to-back sweep transfers
    z_SweepData = 16'h1234; z_SweepReq = 1'b1;
    wait_start(1'b1, "g0");
    check_val("g0_grant", 32'(z_Grant), 32'd2);
    tick(); tick();
    z_SpiDataoutDone = 1'b1; tick(); z_SpiDataoutDone = 1'b0;
    check_val("g0_sweepdone", 32'(z_SweepDone), 32'd1);
    check_val("g0_idle", 32'(z_Busy), 32'd0);
    tick();
    check_val("g0_next_start", 32'(z_Start), 32'd1);
    check_val("g0_next_grant", 32'(z_Grant), 32'd2);
    z_SweepReq = 1'b0;
    tick();
    z_SpiDataoutDone = 1'b1; tick(); z_SpiDataoutDone = 1'b0;
    check_val("g0_second_done", 32'(z_SweepDone), 32'd1);
    tick();
    check_val("g0_no_third", 32'(z_Start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_cfg_scheduler.md
# spi_cfg_scheduler

Shares the single 16-bit SPI master between two requesters: the slow-control host path, which writes configuration words, and the DAC calibration sweep engine. It arbitrates pending requests round-robin and drives the master's start/data inputs. It waits for the master's done pulse, or times out, then enforces a minimum nCS-high gap before the next transfer. It sits between the command decoder / sweep logic and the SPI master.

## Interface
- GAP_CYCLES, 4: idle cycles inserted after each transfer before the next grant (0 allowed).
- TIMEOUT_CYCLES, 255: maximum cycles waiting for SpiDataoutDone before abort (≥ 40).
- Clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- HostReq  in  1  host transfer request; level, held until HostDone.
- HostData  in  16  host word; stable while HostReq high.
- HostDone  out  1  one-cycle pulse: host transfer finished (or timed out).
- SweepReq  in  1  sweep transfer request; same rules as HostReq.
- SweepData  in  16  sweep word.
- SweepDone  out  1  one-cycle pulse: sweep transfer finished (or timed out).
- SpiSerialData  out  16  word to SPI master.
- SpiDataoutStart  out  1  one-cycle start pulse to SPI master.
- SpiDataoutDone  in  1  done pulse from SPI master.
- Busy  out  1  high in any state other than IDLE.
- Grant  out  2  current owner: 0 none, 1 host, 2 sweep.
- TimeoutErr  out  1  sticky; set on timeout.
- ErrClear  in  1  clears TimeoutErr.

## Operation
- Reset values: every output is 0, and the state is IDLE. LastGrant resets to sweep, so the host wins the first tie.
- IDLE: if exactly one Req is high, grant it. If both are high, grant the one not in LastGrant.
  - On grant, the same edge does all of the following: latch its Data into SpiSerialData; set Grant and LastGrant; set SpiDataoutStart=1; clear the wait counter; go to WAIT_DONE.
- WAIT_DONE: SpiDataoutStart returns to 0 on the first edge. The wait counter increments each cycle.
  - When SpiDataoutDone=1: pulse the owner's Done and go to GAP.
  - When the counter reaches TIMEOUT_CYCLES first: set TimeoutErr, pulse the owner's Done, and go to GAP.
- GAP: Grant returns to 0. The gap counter counts GAP_CYCLES, then the block returns to IDLE. With GAP_CYCLES=0, GAP is skipped and the block goes straight to IDLE.
- SpiSerialData holds its last value until the next grant.
- If Req drops during WAIT_DONE, the transfer still completes and Done still pulses. Requests are never preempted.
- A SpiDataoutDone pulse received outside WAIT_DONE is ignored.
- ErrClear and a timeout in the same cycle: set wins.
- Reset mid-transfer: immediate return to reset values and no Done pulse is issued. The SPI master shares reset_n.
- Counter width is $clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)+1). There is no wrap: counters saturate at their terminal values.

## Timing
- Req sampled high at edge N (IDLE): SpiSerialData, Grant and SpiDataoutStart are valid after edge N. SpiDataoutStart is high for exactly one cycle.
- SpiDataoutDone sampled at edge M: the owner's Done is high for the cycle after M.
- Earliest next start pulse: edge M+GAP_CYCLES+1 with GAP_CYCLES≥1; edge M+1 with GAP_CYCLES=0.
- Timeout: Done is asserted TIMEOUT_CYCLES+1 edges after the start edge.
- Req may be re-asserted the cycle after its Done. It is not granted before the gap expires.

## Structure
- Shared package spi_sched_pkg holds:
  - state encoding IDLE/WAIT_DONE/GAP;
  - owner constants OWNER_NONE=0, OWNER_HOST=1, OWNER_SWEEP=2;
  - the 16-bit word width constant.
- Sub-module spi_rr_arb2: a combinational two-input round-robin pick from (HostReq, SweepReq, LastGrant). The FSM, counters and error flag live in the top.

## Test plan
- Single host request with HostData=16'hA5C3, done returned 36 cycles after start:
  - SpiSerialData=16'hA5C3 and one start pulse;
  - HostDone a single cycle, one cycle after done;
  - Busy falls after 4 gap cycles;
  - SweepDone never pulses.
- HostReq and SweepReq both high from reset, with both held through completion: grant order is host, sweep, host, sweep. Each pair of starts is separated by ≥ GAP_CYCLES+1 cycles.
- SpiDataoutDone never returned, TIMEOUT_CYCLES=255: TimeoutErr=1 and HostDone pulse 256 edges after start. A subsequent ErrClear clears the flag; a timeout coincident with ErrClear keeps it set.
- HostReq dropped mid-transfer: transfer completes and HostDone pulses. A spurious SpiDataoutDone during GAP/IDLE produces no Done pulse.
- reset_n pulsed low during WAIT_DONE: all outputs are 0 immediately and no Done pulse follows. After release, a new SweepReq is granted normally.
- GAP_CYCLES=0, back-to-back sweep requests: the next start occurs on the edge after the sweep Done pulse.
